slicel_cfg_loader: RTL and testbench

Configuration sequencer for one slicel instance. Accepts the slice bitstream as a stream of WORD_W-bit words over a valid/ready handshake and assembles it in a shadow register. It then drives the slice configuration buses and pulses the slice config-enable (cen) for a fixed window so that LUTs, the inter-LUT mux, use_cc and the FF initial states are all captured. Sits between the fabric-level config bus and each slicel; cclk and clk of the slice are tied to this block's clk at integration.

---
 rtl/slicel_cfg_loader.sv | 167 ++++++++++++++++
 tb/tb_slicel_cfg_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slicel_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : slicel_cfg_loader
// Brief    : Configuration sequencer for one slicel. Collects the slice
//            bitstream word by word into a shadow register, then holds the
//            slice config-enable high for a fixed window so the slice captures
//            LUT contents, inter-LUT mux select, use_cc and FF init values.
// Revision : 1.0 - initial release
// ============================================================================
module slicel_cfg_loader #(
    parameter int S_XX_BASE  = 4,
    parameter int NUM_LUTS   = 4,
    parameter int WORD_W     = 8,
    parameter int CEN_CYCLES = 2,
    localparam int CFG_SIZE  = 2 * (2 ** S_XX_BASE) + 1,
    localparam int MUX_LVLS  = $clog2(NUM_LUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CFG_SIZE*NUM_LUTS-1:0] luts_config_out,
    output logic [MUX_LVLS-1:0]          inter_lut_mux_config_out,
    output logic                         config_use_cc_out,
    output logic [2*NUM_LUTS-1:0]        regs_config_out,
    output logic                         cen,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted
);

    localparam int LUTS_W    = CFG_SIZE * NUM_LUTS;
    localparam int CFG_TOTAL = LUTS_W + MUX_LVLS + 1 + 2 * NUM_LUTS;
    localparam int NUM_WORDS = (CFG_TOTAL + WORD_W - 1) / WORD_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CEN_W     = (CEN_CYCLES > 1) ? $clog2(CEN_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(NUM_WORDS - 1);
    localparam logic [CEN_W-1:0] c_cen_last  = CEN_W'(CEN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [CEN_W-1:0]       r_cen_cnt;
    logic [CEN_W-1:0]       w_cen_cnt_nxt;
    logic                   r_cen;
    logic                   w_cen_nxt;
    logic                   r_aborted;
    logic                   w_aborted_nxt;
    logic [CFG_TOTAL-1:0]   r_shadow;
    logic [CFG_TOTAL-1:0]   w_shadow_nxt;
    logic                   w_accept;

    // A word presented together with abort is dropped, never written.
    assign w_accept = (r_state == S_LOAD) && in_valid && !abort;

    // Each word owns a fixed slice of the shadow; the last word's slice is
    // truncated so its padding bits simply have nowhere to land.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        localparam int LO = k * WORD_W;
        localparam int NB = ((CFG_TOTAL - LO) < WORD_W) ? (CFG_TOTAL - LO) : WORD_W;
        assign w_shadow_nxt[LO +: NB] = (w_accept && (r_count == CNT_W'(k)))
                                        ? in_data[NB-1:0] : r_shadow[LO +: NB];
    end

    // Next-state, word counter and cen window control.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_cen_cnt_nxt = r_cen_cnt;
        w_cen_nxt     = 1'b0;
        w_aborted_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_LOAD;
                    w_count_nxt = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                    w_aborted_nxt = 1'b1;
                end else if (w_accept) begin
                    if (r_count == c_last_word) begin
                        w_state_nxt   = S_COMMIT;
                        w_count_nxt   = '0;
                        w_cen_cnt_nxt = '0;
                        w_cen_nxt     = 1'b1;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_cen_cnt_nxt = '0;
                    w_aborted_nxt = 1'b1;
                end else if (r_cen_cnt == c_cen_last) begin
                    w_state_nxt   = S_DONE;
                    w_cen_cnt_nxt = '0;
                end else begin
                    w_cen_cnt_nxt = r_cen_cnt + 1'b1;
                    w_cen_nxt     = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control state register; cen is registered so it cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_cen_cnt <= '0;
            r_cen     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_cen_cnt <= w_cen_cnt_nxt;
            r_cen     <= w_cen_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    // Shadow register holding the assembled bitstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else begin
            r_shadow <= w_shadow_nxt;
        end
    end

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign cen      = r_cen;
    assign aborted  = r_aborted;

    assign luts_config_out          = r_shadow[LUTS_W-1:0];
    assign inter_lut_mux_config_out = r_shadow[LUTS_W +: MUX_LVLS];
    assign config_use_cc_out        = r_shadow[LUTS_W + MUX_LVLS];
    assign regs_config_out          = r_shadow[LUTS_W + MUX_LVLS + 1 +: 2*NUM_LUTS];

endmodule
`default_nettype wire

// File: tb/tb_slicel_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_slicel_cfg_loader
// Brief    : Self-checking bench for slicel_cfg_loader with a transaction-level
//            reference model and directed plus randomized load sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slicel_cfg_loader;

    localparam int S_XX_BASE  = 4;
    localparam int NUM_LUTS   = 4;
    localparam int WORD_W     = 8;
    localparam int CEN_CYCLES = 2;
    localparam int CFG_SIZE   = 2 * (2 ** S_XX_BASE) + 1;
    localparam int MUX_LVLS   = $clog2(NUM_LUTS);
    localparam int LUTS_W     = CFG_SIZE * NUM_LUTS;
    localparam int CFG_TOTAL  = LUTS_W + MUX_LVLS + 1 + 2 * NUM_LUTS;
    localparam int NUM_WORDS  = (CFG_TOTAL + WORD_W - 1) / WORD_W;
    localparam int PAD_W      = NUM_WORDS * WORD_W;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic                   abort;
    logic [WORD_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [LUTS_W-1:0]      luts_config_out;
    logic [MUX_LVLS-1:0]    inter_lut_mux_config_out;
    logic                   config_use_cc_out;
    logic [2*NUM_LUTS-1:0]  regs_config_out;
    logic                   cen;
    logic                   busy;
    logic                   done;
    logic                   aborted;

    slicel_cfg_loader #(
        .S_XX_BASE  (S_XX_BASE),
        .NUM_LUTS   (NUM_LUTS),
        .WORD_W     (WORD_W),
        .CEN_CYCLES (CEN_CYCLES)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .abort                    (abort),
        .in_data                  (in_data),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .luts_config_out          (luts_config_out),
        .inter_lut_mux_config_out (inter_lut_mux_config_out),
        .config_use_cc_out        (config_use_cc_out),
        .regs_config_out          (regs_config_out),
        .cen                      (cen),
        .busy                     (busy),
        .done                     (done),
        .aborted                  (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a stream of words fills a padded bit array; once the
    // final word lands, a cen window of CEN_CYCLES cycles follows, then a
    // single done cycle. Values represent what is visible after each edge.
    // ------------------------------------------------------------------
    bit               m_load;
    bit               m_done;
    bit               m_aborted;
    int               m_words;
    int               m_cen_left;
    logic [PAD_W-1:0] m_pad;

    task automatic model_reset();
        m_load     = 1'b0;
        m_done     = 1'b0;
        m_aborted  = 1'b0;
        m_words    = 0;
        m_cen_left = 0;
        m_pad      = '0;
    endtask

    task automatic model_step();
        bit was_load;
        bit was_commit;
        bit was_done;
        was_load   = m_load;
        was_commit = (m_cen_left > 0);
        was_done   = m_done;
        m_done     = 1'b0;
        m_aborted  = 1'b0;
        if (was_load) begin
            if (abort) begin
                m_load    = 1'b0;
                m_aborted = 1'b1;
                m_words   = 0;
            end else if (in_valid) begin
                m_pad[m_words*WORD_W +: WORD_W] = in_data;
                m_words++;
                if (m_words == NUM_WORDS) begin
                    m_load     = 1'b0;
                    m_words    = 0;
                    m_cen_left = CEN_CYCLES;
                end
            end
        end else if (was_commit) begin
            if (abort) begin
                m_cen_left = 0;
                m_aborted  = 1'b1;
            end else begin
                m_cen_left--;
                if (m_cen_left == 0) m_done = 1'b1;
            end
        end else if (!was_done && start && !abort) begin
            m_load  = 1'b1;
            m_words = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Event bookkeeping for the hand-computed timing checks.
    int cen_rise;
    int done_at;
    int cen_cnt;
    int done_cnt;
    int ab_cnt;
    int rdy_cnt;

    task automatic clr_mon();
        cen_rise = -1;
        done_at  = -1;
        cen_cnt  = 0;
        done_cnt = 0;
        ab_cnt   = 0;
        rdy_cnt  = 0;
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready", in_ready, m_load);
                chk("cen",      cen,      m_cen_left > 0);
                chk("done",     done,     m_done);
                chk("aborted",  aborted,  m_aborted);
                chk("busy",     busy,     m_load || (m_cen_left > 0) || m_done);
                chk("luts",     luts_config_out,          m_pad[LUTS_W-1:0]);
                chk("mux",      inter_lut_mux_config_out, m_pad[LUTS_W +: MUX_LVLS]);
                chk("use_cc",   config_use_cc_out,        m_pad[LUTS_W + MUX_LVLS]);
                chk("regs",     regs_config_out,          m_pad[LUTS_W + MUX_LVLS + 1 +: 2*NUM_LUTS]);
                if (cen && cen_rise < 0) cen_rise = cyc;
                if (cen)      cen_cnt++;
                if (done)     begin done_cnt++; done_at = cyc; end
                if (aborted)  ab_cnt++;
                if (in_ready) rdy_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // gap_mode: 0 = valid every cycle, 1 = every other cycle, 2 = random.
    // data_mode: 0 = base+index, 1 = all ones, 2 = random.
    task automatic send_words(input int n, input int gap_mode, input int data_mode,
                              input logic [WORD_W-1:0] base,
                              output int hs_first, output int hs_last);
        int sent;
        int guard;
        bit v;
        bit hs;
        sent     = 0;
        guard    = 0;
        hs_first = -1;
        hs_last  = -1;
        while (sent < n && guard < 400) begin
            guard++;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            case (data_mode)
                0:       in_data = base + WORD_W'(sent);
                1:       in_data = '1;
                default: in_data = WORD_W'($urandom);
            endcase
            if (!v) in_data = WORD_W'($urandom);
            start = ($urandom_range(0, 3) == 0);
            hs = v && in_ready;
            tick();
            if (hs) begin
                sent++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("words_sent", sent, n);
    endtask

    int f;
    int l;
    int found;

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clr_mon();
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        #18;
        chk("rst_luts",     luts_config_out, 0);
        chk("rst_regs",     regs_config_out, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_cen",      cen, 0);
        chk("rst_done",     done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // Full-throughput load of 0x00..0x11. Cycle 1 is the first handshake
        // cycle; cen occupies cycles 19-20 and done cycle 21.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 0, 0, 8'h00, f, l);
        repeat (4) tick();
        chk("t1_ready_cycles", rdy_cnt, 18);
        chk("t1_cen_rise",     cen_rise - f, 17);
        chk("t1_cen_len",      cen_cnt, 2);
        chk("t1_done_at",      done_at - f, 19);
        chk("t1_done_cnt",     done_cnt, 1);
        chk("t1_lut_b0",       luts_config_out[7:0], 8'h00);
        chk("t1_lut_b1",       luts_config_out[15:8], 8'h01);
        chk("t1_regs",         regs_config_out, 8'h22);
        chk("t1_mux",          inter_lut_mux_config_out, 2'b01);
        chk("t1_use_cc",       config_use_cc_out, 1'b0);

        // Same data with in_valid gaps.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 1, 0, 8'h00, f, l);
        repeat (4) tick();
        chk("t2_cen_rise", cen_rise, l);
        chk("t2_done_at",  done_at, l + 2);
        chk("t2_lut_b1",   luts_config_out[15:8], 8'h01);
        chk("t2_lut_b15",  luts_config_out[127:120], 8'h0F);
        chk("t2_regs",     regs_config_out, 8'h22);

        // All ones; padding of the last word is dropped.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 0, 1, 8'h00, f, l);
        repeat (4) tick();
        chk("t3_luts",   luts_config_out, {LUTS_W{1'b1}});
        chk("t3_mux",    inter_lut_mux_config_out, 2'b11);
        chk("t3_use_cc", config_use_cc_out, 1'b1);
        chk("t3_regs",   regs_config_out, 8'hFF);

        // Abort after five words, with a sixth word offered alongside abort.
        clr_mon();
        do_start();
        send_words(5, 0, 0, 8'hA0, f, l);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t4_busy",      busy, 0);
        chk("t4_aborted",   ab_cnt, 1);
        chk("t4_no_cen",    cen_cnt, 0);
        chk("t4_low_bits",  luts_config_out[39:0], 40'hA4A3A2A1A0);
        chk("t4_high_bits", luts_config_out[LUTS_W-1:40], {(LUTS_W-40){1'b1}});
        chk("t4_regs",      regs_config_out, 8'hFF);
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 2, 0, 8'h30, f, l);
        repeat (4) tick();
        chk("t4_reload_b0", luts_config_out[7:0], 8'h30);
        chk("t4_reload_done", done_cnt, 1);

        // Abort during the first cen cycle.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 0, 2, 8'h00, f, l);
        chk("t5_cen_on", cen, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_cen_off",  cen, 0);
        chk("t5_aborted",  aborted, 1);
        repeat (4) tick();
        chk("t5_no_done",  done_cnt, 0);

        // start asserted during the done cycle is ignored.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 0, 2, 8'h00, f, l);
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            if (done) found = 1;
            else      tick();
        end
        chk("t6_done_found", found, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_busy_a", busy, 0);
        tick();
        chk("t6_busy_b", busy, 0);

        // Asynchronous reset in the middle of the cen window.
        clr_mon();
        do_start();
        send_words(NUM_WORDS, 0, 1, 8'h00, f, l);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_cen",      cen, 0);
        chk("t7_luts",     luts_config_out, 0);
        chk("t7_regs",     regs_config_out, 0);
        chk("t7_mux",      inter_lut_mux_config_out, 0);
        chk("t7_busy",     busy, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("t7_in_ready", in_ready, 0);
        chk("t7_idle",     busy, 0);

        // Randomized loads, partial loads with abort, aborts in commit/idle.
        for (int it = 0; it < 12; it++) begin
            int n;
            abort = ($urandom_range(0, 1) == 1);
            tick();
            abort = 1'b0;
            do_start();
            n = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NUM_WORDS - 1) : NUM_WORDS;
            send_words(n, 2, 2, 8'h00, f, l);
            if (n < NUM_WORDS || $urandom_range(0, 3) == 0) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            repeat ($urandom_range(2, 5)) tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
